// File: rtl/osc_scan.sv
// osc_scan: on each sample_tick, visits oscillators 0..N-1 one per cycle. For
// each oscillator it writes back the advanced phase count and adds a +/-velocity
// square-wave term to a signed accumulator. The finished sum is then registered
// into sample_out.
//
// Ports:
//   clk, n_rst        - system clock; asynchronous active-low reset
//   sample_tick       - one-cycle request for a full scan
//   count_sel ..      - state of the oscillator addressed by osc_num
//   ended_note_sel      (driven combinationally by the selector)
//   osc_num           - oscillator index to the selector; N when idle
//   count_wr_en/data  - count write-back for oscillator osc_num
//   sample_out        - signed mixed sample, held between updates
//   sample_valid      - pulses for one cycle when sample_out updates
//   busy              - high while a scan (SCAN or DONE) is in progress
//   overrun           - pulses when a sample_tick arrives while busy
module osc_scan #(
  parameter int unsigned N     = 24,
  parameter int unsigned OUT_W = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             sample_tick,
  input  logic [19:0]      count_sel,
  input  logic [19:0]      max_sel,
  input  logic [6:0]       velocity_sel,
  input  logic             key_pressed_sel,
  input  logic             ended_note_sel,
  output logic [6:0]       osc_num,
  output logic             count_wr_en,
  output logic [19:0]      count_wr_data,
  output logic [OUT_W-1:0] sample_out,
  output logic             sample_valid,
  output logic             busy,
  output logic             overrun
);

  // The accumulator must hold +/-N*127 and is never narrower than 13 bits.
  localparam int unsigned AccRaw  = $clog2(N * 127 + 1) + 1;
  localparam int unsigned AccW    = (AccRaw < 13) ? 13 : AccRaw;
  localparam logic [6:0]  IdleNum = 7'(N);
  localparam logic [6:0]  LastNum = 7'(N - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e                 state_q, state_d;
  logic [6:0]             idx_q, idx_d;
  logic signed [AccW-1:0] acc_q, acc_d;
  logic [OUT_W-1:0]       sample_q, sample_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;

  logic                   active;
  logic [20:0]            cnt_inc;
  logic signed [AccW-1:0] vel_ext;
  logic signed [AccW-1:0] contrib;

  // Per-oscillator datapath, valid whenever osc_num addresses an oscillator.
  always_comb begin
    active  = key_pressed_sel & ~ended_note_sel & (max_sel != 20'd0);
    // 21-bit increment so count_sel = 2^20-1 compares correctly against max_sel.
    cnt_inc = {1'b0, count_sel} + 21'd1;
    vel_ext = {{(AccW - 7){1'b0}}, velocity_sel};
    if (!active) begin
      contrib = '0;
    end else if (count_sel < (max_sel >> 1)) begin
      contrib = vel_ext;
    end else begin
      contrib = -vel_ext;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    acc_d         = acc_q;
    sample_d      = sample_q;
    valid_d       = 1'b0;
    // Any tick outside IDLE (including the DONE cycle) is dropped and flagged.
    overrun_d     = sample_tick & (state_q != StIdle);
    osc_num       = IdleNum;
    count_wr_en   = 1'b0;
    count_wr_data = '0;

    unique case (state_q)
      StIdle: begin
        if (sample_tick) begin
          state_d = StScan;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      StScan: begin
        osc_num     = idx_q;
        count_wr_en = 1'b1;
        if (active && (cnt_inc < {1'b0, max_sel})) begin
          count_wr_data = cnt_inc[19:0];
        end
        acc_d = acc_q + contrib;
        if (idx_q == LastNum) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 7'd1;
        end
      end
      StDone: begin
        // Signed size cast sign-extends the sum to OUT_W.
        sample_d = OUT_W'(acc_q);
        valid_d  = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      acc_q     <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_osc_scan.sv
// tb_osc_scan: directed and randomized scans of osc_scan against a reference
// model that sums the oscillator contributions arithmetically.
module tb_osc_scan;
  localparam int N     = 24;
  localparam int OUT_W = 16;

  logic             clk;
  logic             n_rst;
  logic             sample_tick;
  logic [19:0]      count_sel;
  logic [19:0]      max_sel;
  logic [6:0]       velocity_sel;
  logic             key_pressed_sel;
  logic             ended_note_sel;
  logic [6:0]       osc_num;
  logic             count_wr_en;
  logic [19:0]      count_wr_data;
  logic [OUT_W-1:0] sample_out;
  logic             sample_valid;
  logic             busy;
  logic             overrun;

  // Oscillator bank seen by the DUT through osc_num.
  int cnt_a [N];
  int max_a [N];
  int vel_a [N];
  bit key_a [N];
  bit end_a [N];

  int n_tests = 0;
  int n_fail  = 0;

  osc_scan #(.N(N), .OUT_W(OUT_W)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .sample_tick    (sample_tick),
    .count_sel      (count_sel),
    .max_sel        (max_sel),
    .velocity_sel   (velocity_sel),
    .key_pressed_sel(key_pressed_sel),
    .ended_note_sel (ended_note_sel),
    .osc_num        (osc_num),
    .count_wr_en    (count_wr_en),
    .count_wr_data  (count_wr_data),
    .sample_out     (sample_out),
    .sample_valid   (sample_valid),
    .busy           (busy),
    .overrun        (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    int k;
    k               = int'(osc_num);
    count_sel       = '0;
    max_sel         = '0;
    velocity_sel    = '0;
    key_pressed_sel = 1'b0;
    ended_note_sel  = 1'b0;
    if (k < N) begin
      count_sel       = 20'(cnt_a[k]);
      max_sel         = 20'(max_a[k]);
      velocity_sel    = 7'(vel_a[k]);
      key_pressed_sel = key_a[k];
      ended_note_sel  = end_a[k];
    end
  end

  function automatic bit is_active(int i);
    return key_a[i] && !end_a[i] && (max_a[i] != 0);
  endfunction

  function automatic int exp_wdata(int i);
    if (!is_active(i)) return 0;
    return (cnt_a[i] + 1 >= max_a[i]) ? 0 : cnt_a[i] + 1;
  endfunction

  function automatic int exp_sum();
    int s = 0;
    for (int i = 0; i < N; i++) begin
      if (is_active(i)) s += (cnt_a[i] < max_a[i] / 2) ? vel_a[i] : -vel_a[i];
    end
    return s;
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      cnt_a[i] = 0; max_a[i] = 0; vel_a[i] = 0; key_a[i] = 0; end_a[i] = 0;
    end
  endtask

  task automatic set_osc(input int i, input int cnt, input int mx, input int vel);
    key_a[i] = 1; end_a[i] = 0; cnt_a[i] = cnt; max_a[i] = mx; vel_a[i] = vel;
  endtask

  task automatic randomize_all();
    for (int i = 0; i < N; i++) begin
      int sel;
      key_a[i] = ($urandom_range(0, 3) != 0);
      end_a[i] = ($urandom_range(0, 4) == 0);
      vel_a[i] = $urandom_range(0, 127);
      max_a[i] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 20'hFFFFF);
      sel = $urandom_range(0, 3);
      if (sel == 0 || max_a[i] == 0) cnt_a[i] = $urandom_range(0, 20'hFFFFF);
      else if (sel == 1)             cnt_a[i] = max_a[i] - 1;
      else                           cnt_a[i] = $urandom_range(0, max_a[i] - 1);
    end
  endtask

  // One full scan. extra_at: scan cycle (0..N-1) or N (the DONE cycle) at which a
  // second tick is injected; -1 for none.
  task automatic do_scan(input string name, input int extra_at);
    int s;
    s = exp_sum();
    @(negedge clk); sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_osc_num%0d", name, i), int'(osc_num), i);
      chk($sformatf("%s_wr_en%0d", name, i), int'(count_wr_en), 1);
      chk($sformatf("%s_wdata%0d", name, i), int'(count_wr_data), exp_wdata(i));
      chk($sformatf("%s_busy%0d", name, i), int'(busy), 1);
      chk($sformatf("%s_valid%0d", name, i), int'(sample_valid), 0);
      chk($sformatf("%s_overrun%0d", name, i), int'(overrun),
          (extra_at >= 0 && i == extra_at + 1) ? 1 : 0);
      sample_tick = (i == extra_at);
      @(negedge clk);
      sample_tick = 1'b0;
    end
    chk({name, "_done_osc_num"}, int'(osc_num), N);
    chk({name, "_done_wr_en"}, int'(count_wr_en), 0);
    chk({name, "_done_busy"}, int'(busy), 1);
    chk({name, "_done_valid"}, int'(sample_valid), 0);
    chk({name, "_done_overrun"}, int'(overrun), (extra_at == N - 1) ? 1 : 0);
    sample_tick = (extra_at == N);
    @(negedge clk);
    sample_tick = 1'b0;
    chk({name, "_valid"}, int'(sample_valid), 1);
    chk({name, "_sample"}, int'($signed(sample_out)), s);
    chk({name, "_idle_busy"}, int'(busy), 0);
    chk({name, "_idle_osc_num"}, int'(osc_num), N);
    chk({name, "_idle_overrun"}, int'(overrun), (extra_at == N) ? 1 : 0);
    @(negedge clk);
    chk({name, "_valid_drop"}, int'(sample_valid), 0);
    chk({name, "_sample_hold"}, int'($signed(sample_out)), s);
    chk({name, "_no_restart"}, int'(busy), 0);
  endtask

  initial begin
    n_rst       = 1'b0;
    sample_tick = 1'b0;
    clear_all();

    #12;
    chk("rst_osc_num", int'(osc_num), N);
    chk("rst_sample", int'(sample_out), 0);
    chk("rst_valid", int'(sample_valid), 0);
    chk("rst_wr_en", int'(count_wr_en), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk); n_rst = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", int'(osc_num), N);

    // All inactive.
    do_scan("inactive", -1);

    // Single active oscillators, low and high half.
    clear_all(); set_osc(3, 10, 100, 127);
    do_scan("osc3_pos", -1);
    clear_all(); set_osc(5, 99, 100, 64);
    do_scan("osc5_neg", -1);

    // Full-scale sums.
    clear_all();
    for (int i = 0; i < N; i++) set_osc(i, 0, 100, 127);
    do_scan("all_low", -1);
    for (int i = 0; i < N; i++) set_osc(i, 60, 100, 127);
    do_scan("all_high", -1);

    // 21-bit increment boundary, gating by ended/max=0, and odd period midpoint.
    clear_all();
    set_osc(7, 20'hFFFFF, 20'hFFFFF, 50);
    set_osc(8, 20'hFFFFE, 20'hFFFFF, 40);
    set_osc(9, 5, 0, 90);
    set_osc(10, 5, 100, 90); end_a[10] = 1;
    set_osc(11, 2, 5, 30);
    set_osc(12, 1, 5, 20);
    set_osc(13, 200, 100, 10);
    do_scan("bounds", -1);

    // Overrun during SCAN and during DONE.
    randomize_all();
    do_scan("ovr_scan5", 5);
    randomize_all();
    do_scan("ovr_done", N);

    // Reset mid-scan.
    randomize_all();
    @(negedge clk); sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    for (int i = 0; i < 10; i++) @(negedge clk);
    chk("mid_osc_num", int'(osc_num), 10);
    n_rst = 1'b0;
    #1;
    chk("mid_rst_osc_num", int'(osc_num), N);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_wr_en", int'(count_wr_en), 0);
    chk("mid_rst_sample", int'(sample_out), 0);
    @(negedge clk); @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < N + 4; i++) begin
      chk($sformatf("mid_rst_novalid%0d", i), int'(sample_valid), 0);
      @(negedge clk);
    end
    do_scan("after_rst", -1);

    // Randomized scans.
    for (int r = 0; r < 6; r++) begin
      randomize_all();
      do_scan($sformatf("rand%0d", r), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
